// File: rtl/vproc_pkg.sv
// Shared types, opcodes and lane arithmetic helpers for the vector execute stage.
// VEXEC_SAT_EN selects signed saturation; without it, arithmetic wraps.
package vproc_pkg;

    localparam int LANE_W    = 16;
    localparam int NUM_LANES = 16;
    localparam int VEC_W     = LANE_W * NUM_LANES;

    localparam logic [3:0] FT_VADD = 4'h0;
    localparam logic [3:0] FT_VDOT = 4'h1;
    localparam logic [3:0] FT_SMUL = 4'h2;
    localparam logic [3:0] FT_SST  = 4'h3;
    localparam logic [3:0] FT_VLD  = 4'h4;
    localparam logic [3:0] FT_VST  = 4'h5;
    localparam logic [3:0] FT_SLL  = 4'h6;
    localparam logic [3:0] FT_SLH  = 4'h7;
    localparam logic [3:0] FT_J    = 4'h8;
    localparam logic [3:0] FT_NOP  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_vector(input logic [3:0] ft);
        return (ft == FT_VADD) || (ft == FT_VDOT) || (ft == FT_SMUL);
    endfunction

    // Returns {ovf, sum}; ovf is only ever set in the saturating build.
    function automatic logic [LANE_W:0] lane_add(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
`ifdef VEXEC_SAT_EN
        logic [LANE_W:0] s;
        s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        if (s[LANE_W] != s[LANE_W-1])
            return {1'b1, (s[LANE_W] ? 16'h8000 : 16'h7FFF)};
        return {1'b0, s[LANE_W-1:0]};
`else
        return {1'b0, a + b};
`endif
    endfunction

endpackage

// File: rtl/vexec_lane.sv
// One 16-bit lane: signed add or multiply, saturating when VEXEC_SAT_EN is defined.
// prod_o is always the wrapped low half of the product (used by the dot accumulator).
module vexec_lane
    import vproc_pkg::*;
(
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic              mul_i,
    output logic [LANE_W-1:0] res_o,
    output logic [LANE_W-1:0] prod_o,
    output logic              ovf_o
);

    logic [LANE_W:0]   add_r;
    logic [LANE_W-1:0] mul_res;
    logic              mul_ovf;

`ifdef VEXEC_SAT_EN
    logic signed [2*LANE_W-1:0] prod_full;
    assign prod_full = $signed(a_i) * $signed(b_i);
    assign prod_o    = prod_full[LANE_W-1:0];
    assign mul_ovf   = (prod_full[2*LANE_W-1:LANE_W-1] != {(LANE_W+1){prod_full[LANE_W-1]}});
    assign mul_res   = mul_ovf ? (prod_full[2*LANE_W-1] ? 16'h8000 : 16'h7FFF)
                               : prod_full[LANE_W-1:0];
`else
    assign prod_o  = a_i * b_i;
    assign mul_ovf = 1'b0;
    assign mul_res = prod_o;
`endif

    assign add_r = lane_add(a_i, b_i);

    always_comb begin
        res_o = add_r[LANE_W-1:0];
        ovf_o = add_r[LANE_W];
        if (mul_i) begin
            res_o = mul_res;
            ovf_o = mul_ovf;
        end
    end

endmodule

// File: rtl/vector_exec_unit.sv
// Execute stage: latches an op at start, runs vector ops a slice per cycle, pulses done.
// VEXEC_SAT_EN enables saturating lane arithmetic and a live ovf output.
module vector_exec_unit
    import vproc_pkg::*;
#(
    parameter int LANES_PER_CYCLE = 4,
    parameter int NUM_LANES       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       functype_i,
    input  logic [VEC_W-1:0] op1_i,
    input  logic [VEC_W-1:0] op2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [VEC_W-1:0] result_o,
    output logic             ovf_o
);

    localparam int L        = LANES_PER_CYCLE;
    localparam int N_SLICES = NUM_LANES / L;
    localparam int SLICE_W  = L * LANE_W;

    if (!(L == 1 || L == 2 || L == 4 || L == 8 || L == 16) || NUM_LANES != vproc_pkg::NUM_LANES) begin : g_bad_cfg
        $error("vector_exec_unit: LANES_PER_CYCLE must be 1,2,4,8 or 16 and NUM_LANES must be 16");
    end

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       func_q, func_d;
    logic [VEC_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [VEC_W-1:0] work_q, work_d;
    logic [VEC_W-1:0] result_q, result_d;
    logic [LANE_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic             ovf_q, ovf_d;

    logic [8:0]                        slice_base;
    logic [SLICE_W-1:0]                slice_op1, slice_op2;
    logic [L-1:0][LANE_W-1:0]          lane_res, lane_prod;
    logic [L-1:0]                      lane_ovf;
    logic                              is_smul;

    assign slice_base = 9'(cnt_q) * 9'(SLICE_W);
    assign slice_op1  = SLICE_W'(op1_q >> slice_base);
    assign slice_op2  = SLICE_W'(op2_q >> slice_base);
    assign is_smul    = (func_q == FT_SMUL);

    for (genvar g = 0; g < L; g++) begin : g_lane
        vexec_lane u_lane (
            .a_i    (slice_op1[g*LANE_W +: LANE_W]),
            .b_i    (is_smul ? op2_q[LANE_W-1:0] : slice_op2[g*LANE_W +: LANE_W]),
            .mul_i  (func_q != FT_VADD),
            .res_o  (lane_res[g]),
            .prod_o (lane_prod[g]),
            .ovf_o  (lane_ovf[g])
        );
    end

    logic [LANE_W-1:0] scalar_res;
    logic [LANE_W-1:0] acc_step;
    logic              dot_ovf;
    logic [LANE_W:0]   add_tmp;
    logic              step_ovf;
    logic              last;
    logic [VEC_W-1:0]  final_res;

    always_comb begin
        scalar_res = '0;
        case (func_q)
            FT_SST, FT_VLD, FT_VST, FT_J: scalar_res = op1_q[15:0] + op2_q[15:0];
            FT_SLL:                       scalar_res = {op1_q[15:8], op2_q[7:0]};
            FT_SLH:                       scalar_res = {op2_q[7:0], op1_q[7:0]};
            default:                      scalar_res = '0;
        endcase
    end

    // Dot products accumulate lane by lane in ascending order, one saturation check per add.
    always_comb begin
        acc_step = acc_q;
        dot_ovf  = 1'b0;
        add_tmp  = '0;
        for (int i = 0; i < L; i++) begin
            add_tmp  = lane_add(acc_step, lane_prod[i]);
            acc_step = add_tmp[LANE_W-1:0];
            dot_ovf  = dot_ovf | add_tmp[LANE_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        func_d    = func_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        work_d    = work_q;
        result_d  = result_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
        step_ovf  = 1'b0;
        last      = 1'b0;
        final_res = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = EXEC;
                    cnt_d     = '0;
                    func_d    = functype_i;
                    op1_d     = op1_i;
                    op2_d     = op2_i;
                    work_d    = '0;
                    result_d  = '0;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            EXEC: begin
                if (is_vector(func_q)) begin
                    last  = (cnt_q == 4'(N_SLICES - 1));
                    cnt_d = cnt_q + 4'd1;
                    if (func_q == FT_VDOT) begin
                        step_ovf  = dot_ovf;
                        acc_d     = acc_step;
                        final_res = {{(VEC_W-LANE_W){1'b0}}, acc_step};
                    end else begin
                        step_ovf  = |lane_ovf;
                        work_d    = work_q | (VEC_W'(lane_res) << slice_base);
                        final_res = work_d;
                    end
                    ovf_acc_d = ovf_acc_q | step_ovf;
                end else begin
                    last      = 1'b1;
                    final_res = {{(VEC_W-LANE_W){1'b0}}, scalar_res};
                end
                if (last) begin
                    state_d  = DONE;
                    result_d = final_res;
                    ovf_d    = ovf_acc_q | step_ovf;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            func_q    <= FT_NOP;
            op1_q     <= '0;
            op2_q     <= '0;
            work_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            func_q    <= func_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            work_q    <= work_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Bench for vector_exec_unit: three instances (4, 1 and 16 lanes per cycle) against a lane-level reference model.
module tb_vector_exec_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   start_w = '0;
    logic [3:0]   functype = 4'hF;
    logic [255:0] op1 = '0, op2 = '0;
    logic [2:0]   busy_w, done_w, ovf_w;
    logic [255:0] res_w [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_exec_unit #(.LANES_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start_w[0]), .functype_i(functype),
        .op1_i(op1), .op2_i(op2), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .result_o(res_w[0]), .ovf_o(ovf_w[0]));

    vector_exec_unit #(.LANES_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_w[1]), .functype_i(functype),
        .op1_i(op1), .op2_i(op2), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .result_o(res_w[1]), .ovf_o(ovf_w[1]));

    vector_exec_unit #(.LANES_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start_w[2]), .functype_i(functype),
        .op1_i(op1), .op2_i(op2), .busy_o(busy_w[2]), .done_o(done_w[2]),
        .result_o(res_w[2]), .ovf_o(ovf_w[2]));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int lanes_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    function automatic int sx(input logic [255:0] v, input int i);
        logic [15:0] t;
        t = v[16*i +: 16];
        return int'($signed(t));
    endfunction

    // {ovf, value}: clamp in the saturating build, plain modulo-2^16 otherwise.
    function automatic logic [16:0] fit(input int s);
`ifdef VEXEC_SAT_EN
        if (s > 32767)  return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, 16'(s)};
    endfunction

    function automatic logic [256:0] model(input logic [3:0] f, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        logic         o;
        logic [16:0]  x;
        int           acc;
        r = '0;
        o = 1'b0;
        case (f)
            4'h0: for (int i = 0; i < 16; i++) begin
                      x = fit(sx(a, i) + sx(b, i));
                      r[16*i +: 16] = x[15:0];
                      o |= x[16];
                  end
            4'h2: for (int i = 0; i < 16; i++) begin
                      x = fit(sx(a, i) * sx(b, 0));
                      r[16*i +: 16] = x[15:0];
                      o |= x[16];
                  end
            4'h1: begin
                      acc = 0;
                      for (int i = 0; i < 16; i++) begin
                          x = fit(acc + int'($signed(16'(sx(a, i) * sx(b, i)))));
                          acc = int'($signed(x[15:0]));
                          o |= x[16];
                      end
                      r[15:0] = 16'(acc);
                  end
            4'h3, 4'h4, 4'h5, 4'h8: r[15:0] = 16'((a[15:0] + b[15:0]) % 65536);
            4'h6: r[15:0] = {a[15:8], b[7:0]};
            4'h7: r[15:0] = {b[7:0], a[7:0]};
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    task automatic run_op(input int d, input logic [3:0] f, input logic [255:0] a,
                          input logic [255:0] b, input bit hold, input string tag,
                          output logic [255:0] got_res);
        logic [256:0] exp;
        int exp_cyc, cyc;
        bit got;
        exp     = model(f, a, b);
        exp_cyc = (f <= 4'h2) ? (16 / lanes_of(d)) + 1 : 2;
        @(negedge clk);
        functype   = f;
        op1        = a;
        op2        = b;
        start_w[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_w[d] = 1'b0;
        functype = 4'($urandom_range(0, 15));
        op1      = ~a;
        op2      = ~b;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            if (done_w[d]) begin
                got = 1'b1;
            end else begin
                chk({tag, " busy"}, 256'(busy_w[d]), 256'd1);
                @(negedge clk);
                cyc++;
            end
        end
        start_w[d] = 1'b0;
        got_res    = res_w[d];
        chk({tag, " done"}, 256'(got), 256'd1);
        chk({tag, " latency"}, 256'(cyc), 256'(exp_cyc));
        chk({tag, " result"}, res_w[d], exp[255:0]);
        chk({tag, " ovf"}, 256'(ovf_w[d]), 256'(exp[256]));
        @(negedge clk);
        chk({tag, " done pulse"}, 256'(done_w[d]), 256'd0);
        chk({tag, " idle"}, 256'(busy_w[d]), 256'd0);
        chk({tag, " held"}, res_w[d], exp[255:0]);
    endtask

    logic [255:0] va, vb, r;

    initial begin
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst busy", 256'(busy_w[d]), 256'd0);
            chk("rst done", 256'(done_w[d]), 256'd0);
            chk("rst result", res_w[d], 256'd0);
            chk("rst ovf", 256'(ovf_w[d]), 256'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            va[16*i +: 16] = 16'(i + 1);
            vb[16*i +: 16] = 16'h0010;
        end
        for (int d = 0; d < 3; d++) begin
            run_op(d, 4'h0, va, vb, (d == 0), "vadd", r);
            chk("vadd lane0", 256'(r[15:0]), 256'd17);
            chk("vadd lane15", 256'(r[255:240]), 256'd32);
        end

        for (int i = 0; i < 16; i++) begin
            va[16*i +: 16] = 16'd2;
            vb[16*i +: 16] = 16'd3;
        end
        run_op(0, 4'h1, va, vb, 1'b0, "vdot", r);
        chk("vdot value", r, 256'd96);

        va = '0;
        va[15:0] = 16'h4000;
        vb = '0;
        vb[15:0] = 16'd2;
        run_op(0, 4'h2, va, vb, 1'b0, "smul", r);
`ifdef VEXEC_SAT_EN
        chk("smul lane0", 256'(r[15:0]), 256'h7FFF);
`else
        chk("smul lane0", 256'(r[15:0]), 256'h8000);
`endif

        va = '0;
        va[15:0] = 16'hAB12;
        vb = '0;
        vb[7:0] = 8'h34;
        run_op(0, 4'h6, va, vb, 1'b0, "sll", r);
        chk("sll value", r, 256'hAB34);

        // Abort mid-operation: reset while start is still held.
        for (int i = 0; i < 16; i++) begin
            va[16*i +: 16] = 16'(i + 1);
            vb[16*i +: 16] = 16'h0010;
        end
        @(negedge clk);
        functype   = 4'h0;
        op1        = va;
        op2        = vb;
        start_w[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy before", 256'(busy_w[0]), 256'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 256'(busy_w[0]), 256'd0);
        chk("abort done", 256'(done_w[0]), 256'd0);
        chk("abort result", res_w[0], 256'd0);
        start_w[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done_w[0] || busy_w[0]) seen++;
            end
            chk("abort no done", 256'(seen), 256'd0);
        end

        for (int n = 0; n < 24; n++) begin
            int d;
            logic [3:0] f;
            d = $urandom_range(0, 2);
            f = 4'($urandom_range(0, 15));
            for (int w = 0; w < 8; w++) begin
                va[32*w +: 32] = $urandom;
                vb[32*w +: 32] = $urandom;
            end
            if (n % 3 == 0) begin
                for (int i = 0; i < 16; i++) begin
                    va[16*i +: 16] = 16'($signed(va[16*i +: 5]));
                    vb[16*i +: 16] = 16'($signed(vb[16*i +: 5]));
                end
            end
            run_op(d, f, va, vb, n[0], "rand", r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck want finish");
        $fatal(1, "bench time limit");
    end

endmodule
